uart_buffered: RTL
==================

// Module: uart_buffered
// PURPOSE
//  Parametrised buffered UART: TX and RX engines with per-direction FIFOs.
//  Adds 16x-oversampled RX, error tagging, overrun detection and internal loopback.
//  Sits between a host-side valid/ready bus and the serial pins; replaces unbuffered TX/RX pairs.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame, legal 5..9, sent LSB first
//  FIFO_DEPTH  16  entries per FIFO, power of 2, >=2
//  DIV_WIDTH   16  width of baud_div
// PORTS
//  clk            in   1           system clock
//  rst            in   1           synchronous, active-high reset
//  baud_div       in   DIV_WIDTH   oversample tick every baud_div+1 clocks; 16 ticks per bit
//  parity_mode    in   2           0 none, 1 even, 2 odd, 3 treated as none
//  stop_bits      in   1           0: 1 stop bit, 1: 2 stop bits
//  loopback       in   1           1: TX serial output feeds RX internally
//  tx_data        in   DATA_WIDTH  byte to transmit
//  tx_valid       in   1           write request
//  tx_ready       out  1           TX FIFO not full
//  tx_level       out  LW          TX FIFO occupancy, LW=$clog2(FIFO_DEPTH+1)
//  tx_busy        out  1           TX FSM not IDLE
//  rx_data        out  DATA_WIDTH  RX FIFO head (first-word fall-through)
//  rx_valid       out  1           RX FIFO not empty
//  rx_ready       in   1           pop RX head when rx_valid
//  rx_parity_err  out  1           head entry parity error, qualified by rx_valid
//  rx_frame_err   out  1           head entry stop-bit error, qualified by rx_valid
//  rx_level       out  LW          RX FIFO occupancy
//  rx_overrun     out  1           sticky: a frame was dropped because RX FIFO was full
//  rx_ovr_clr     in   1           clears rx_overrun; a drop in the same cycle wins
//  uart_tx        out  1           serial out, idle high
//  uart_rx        in   1           serial in, asynchronous
// BEHAVIOUR
//  Reset:
//   - uart_tx=1, tx_ready=1, tx_busy=0, rx_valid=0, all flags 0, levels 0.
//   - Both FIFOs emptied, FSMs to IDLE; applies mid-frame too.
//  FIFOs:
//   - Write on tx_valid&&tx_ready; writes while tx_ready=0 are ignored.
//   - RX push when full and pop in the same cycle: both happen, level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  TX FSM: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP1 -> STOP2 (if stop_bits) -> IDLE.
//   - In IDLE with TX FIFO non-empty: pop and latch config, restart TX prescaler; uart_tx=0 next cycle.
//   - Into an empty idle FIFO, uart_tx falls 2 clocks after the accepting edge.
//   - Each bit lasts exactly 16*(baud_div+1) clocks.
//   - Back-to-back frames carry no idle gap.
//   - Parity = XOR of data bits; odd mode inverts it.
//  RX path:
//   - 2-flop synchroniser; input source is uart_tx-internal when loopback=1.
//   - IDLE: on falling edge, restart RX prescaler and go to START.
//   - START: sample at tick 8; if high -> IDLE (glitch rejected), else go to DATA.
//   - DATA, PARITY, STOP: each bit sampled at its tick 8.
//   - Parity error on mismatch. Frame error if any checked stop bit is 0.
//   - After the last stop sample, push {parity_err, frame_err, data} and return to IDLE.
//   - If the RX FIFO is full, drop the frame and set rx_overrun.
//   - Config latched at start detect; changes mid-frame take effect on the next frame.
//  Loopback:
//   - uart_tx pin is held 1.
//   - External uart_rx is ignored.
// TESTING
//  T1 loopback, 8N1, baud_div=0; write A5,3C,FF,00 -> RX pops same order, no errors, uart_tx pin stays 1.
//  T2 8E2, baud_div=0, tx 0x53 -> uart_tx 0,1,1,0,0,1,0,1,0, parity 0, then 1,1; each bit 16 clks.
//  T2 (cont.) -> first low 2 clks after accept; tx_busy high for 192 clks.
//  T3 write FIFO_DEPTH+3 bytes back-to-back -> tx_ready low whenever tx_level==16; extra writes dropped.
//  T3 (cont.) -> all accepted bytes appear on the wire in order.
//  T4 rx_ready=0, drive 17 frames 0x11..0x21 -> rx_level=16, rx_overrun=1, head 0x11, 0x21 absent.
//  T4 (cont.) -> rx_ovr_clr pulse clears rx_overrun.
//  T5 8O1, 0x55 with wrong parity -> rx_parity_err=1; 0x55 with stop=0 -> rx_frame_err=1.
//  T5 (cont.) -> data 0x55 in both cases.
//  T6 uart_rx low for 4 clks (baud_div=0) -> no push.
//  T6 (cont.) -> rst asserted mid-TX-frame -> uart_tx=1 next clk, levels 0.

Source files
------------

// File: rtl/uart_buffered.sv
// uart_buffered: 16x-oversampled UART with TX/RX FIFOs,
// parity/framing tags, sticky overrun and internal loopback.
module uart_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  input  logic                  loopback,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [LW-1:0]         tx_level,
  output logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic [LW-1:0]         rx_level,
  output logic                  rx_overrun,
  input  logic                  rx_ovr_clr,
  output logic                  uart_tx,
  input  logic                  uart_rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = DATA_WIDTH + 2;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [3:0] LAST = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
    S_PAR, S_STOP1, S_STOP2
  } st_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wp, tx_rp;
  logic [LW-1:0]         tx_cnt;
  logic                  tx_wr, tx_pop, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_ready = tx_cnt != FULL;
  assign tx_empty = tx_cnt == '0;
  assign tx_wr    = tx_valid && tx_ready;
  assign tx_level = tx_cnt;
  assign tx_head  = tx_mem[tx_rp];

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_wr)  tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (tx_wr && !tx_pop)
        tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_wr && tx_pop)
        tx_cnt <= tx_cnt - 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= tx_data;
  end

  // ---------------- TX engine ----------------
  st_t                   tx_st, tx_nx;
  logic [DIV_WIDTH-1:0]  tx_pre, tx_bd;
  logic [3:0]            tx_tc, tx_bc;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  tx_par, tx_pen, tx_stop2;
  logic                  tx_q, tx_bit, tx_fin;
  logic                  tx_tick, tx_done;

  assign tx_tick = tx_pre == tx_bd;
  assign tx_done = tx_tick && (tx_tc == 4'hF);
  assign tx_busy = tx_st != S_IDLE;
  assign uart_tx = loopback ? 1'b1 : tx_q;

  // TX next state, pop request and line level
  always_comb begin
    tx_nx  = tx_st;
    tx_pop = 1'b0;
    tx_bit = 1'b1;
    tx_fin = 1'b0;
    unique case (tx_st)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_nx  = S_START;
          tx_pop = 1'b1;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (tx_done) tx_nx = S_DATA;
      end
      S_DATA: begin
        tx_bit = tx_sh[0];
        if (tx_done && tx_bc == LAST)
          tx_nx = tx_pen ? S_PAR : S_STOP1;
      end
      S_PAR: begin
        tx_bit = tx_par;
        if (tx_done) tx_nx = S_STOP1;
      end
      S_STOP1: begin
        if (tx_done) begin
          if (tx_stop2) tx_nx = S_STOP2;
          else          tx_fin = 1'b1;
        end
      end
      S_STOP2: begin
        if (tx_done) tx_fin = 1'b1;
      end
      default: tx_nx = S_IDLE;
    endcase
    // chain straight into the next frame
    if (tx_fin) begin
      tx_nx  = tx_empty ? S_IDLE : S_START;
      tx_pop = !tx_empty;
    end
  end

  // TX state, prescaler, shifter and registered pin
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st    <= S_IDLE;
      tx_q     <= 1'b1;
      tx_pre   <= '0;
      tx_bd    <= '0;
      tx_tc    <= '0;
      tx_bc    <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      tx_q  <= tx_bit;
      if (tx_pop) begin
        tx_sh    <= tx_head;
        tx_par   <= ^tx_head ^ (parity_mode == 2'd2);
        tx_pen   <= (parity_mode == 2'd1) ||
                    (parity_mode == 2'd2);
        tx_stop2 <= stop_bits;
        tx_bd    <= baud_div;
        tx_pre   <= '0;
        tx_tc    <= '0;
        tx_bc    <= '0;
      end else if (tx_st != S_IDLE) begin
        if (tx_tick) begin
          tx_pre <= '0;
          tx_tc  <= tx_tc + 1'b1;
          if (tx_tc == 4'hF && tx_st == S_DATA) begin
            tx_sh <= tx_sh >> 1;
            tx_bc <= tx_bc + 1'b1;
          end
        end else begin
          tx_pre <= tx_pre + 1'b1;
        end
      end
    end
  end

  // ---------------- RX engine ----------------
  logic                  rs1, rs2, rprev, rx_fall;
  st_t                   rx_st, rx_nx;
  logic [DIV_WIDTH-1:0]  rx_pre, rx_bd;
  logic [3:0]            rx_tc, rx_bc;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  rx_pen, rx_odd, rx_stop2;
  logic                  rx_perr, rx_ferr;
  logic                  rx_tick, rx_smp, rx_push;
  logic [RW-1:0]         rx_word;

  assign rx_fall = rprev && !rs2;
  assign rx_tick = rx_pre == rx_bd;
  assign rx_smp  = rx_tick && (rx_tc == 4'd7);
  assign rx_word = {rx_perr, rx_ferr | !rs2, rx_sh};

  // two-flop synchroniser plus edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1   <= 1'b1;
      rs2   <= 1'b1;
      rprev <= 1'b1;
    end else begin
      rs1   <= loopback ? tx_q : uart_rx;
      rs2   <= rs1;
      rprev <= rs2;
    end
  end

  // RX next state and push strobe
  always_comb begin
    rx_nx   = rx_st;
    rx_push = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        if (rx_fall) rx_nx = S_START;
      end
      S_START: begin
        if (rx_smp) rx_nx = rs2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_smp && rx_bc == LAST)
          rx_nx = rx_pen ? S_PAR : S_STOP1;
      end
      S_PAR: begin
        if (rx_smp) rx_nx = S_STOP1;
      end
      S_STOP1: begin
        if (rx_smp) begin
          if (rx_stop2) begin
            rx_nx = S_STOP2;
          end else begin
            rx_nx   = S_IDLE;
            rx_push = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (rx_smp) begin
          rx_nx   = S_IDLE;
          rx_push = 1'b1;
        end
      end
      default: rx_nx = S_IDLE;
    endcase
  end

  // RX state, prescaler, sampling and error tags
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st    <= S_IDLE;
      rx_pre   <= '0;
      rx_bd    <= '0;
      rx_tc    <= '0;
      rx_bc    <= '0;
      rx_sh    <= '0;
      rx_pen   <= 1'b0;
      rx_odd   <= 1'b0;
      rx_stop2 <= 1'b0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_st <= rx_nx;
      if (rx_st == S_IDLE) begin
        if (rx_fall) begin
          rx_pre   <= '0;
          rx_tc    <= '0;
          rx_bc    <= '0;
          rx_bd    <= baud_div;
          rx_pen   <= (parity_mode == 2'd1) ||
                      (parity_mode == 2'd2);
          rx_odd   <= parity_mode == 2'd2;
          rx_stop2 <= stop_bits;
          rx_perr  <= 1'b0;
          rx_ferr  <= 1'b0;
        end
      end else begin
        if (rx_tick) begin
          rx_pre <= '0;
          rx_tc  <= rx_tc + 1'b1;
        end else begin
          rx_pre <= rx_pre + 1'b1;
        end
        if (rx_smp) begin
          case (rx_st)
            S_DATA: begin
              rx_sh <= {rs2, rx_sh[DATA_WIDTH-1:1]};
              rx_bc <= rx_bc + 1'b1;
            end
            S_PAR:   rx_perr <= (^rx_sh ^ rx_odd) != rs2;
            S_STOP1: rx_ferr <= rx_ferr | !rs2;
            S_STOP2: rx_ferr <= rx_ferr | !rs2;
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [LW-1:0] rx_cnt;
  logic          rx_full, rx_pop, rx_wr, rx_drop;
  logic [RW-1:0] rx_head;

  assign rx_full  = rx_cnt == FULL;
  assign rx_valid = rx_cnt != '0;
  assign rx_pop   = rx_ready && rx_valid;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_drop  = rx_push && rx_full && !rx_pop;
  assign rx_head  = rx_mem[rx_rp];
  assign rx_data  = rx_head[DATA_WIDTH-1:0];
  assign rx_frame_err  = rx_valid && rx_head[DATA_WIDTH];
  assign rx_parity_err = rx_valid && rx_head[DATA_WIDTH+1];
  assign rx_level = rx_cnt;

  // RX FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_wr && !rx_pop)
        rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_wr && rx_pop)
        rx_cnt <= rx_cnt - 1'b1;
      if (rx_drop)
        rx_overrun <= 1'b1;
      else if (rx_ovr_clr)
        rx_overrun <= 1'b0;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_word;
  end

endmodule
